apb_cmd_master: RTL and testbench

- APB initiator that drives the timer register interface (sel/write/enable/address/wdata, ready/slverr/rdata) from a simple valid/ready command port.
- Used by bench firmware models and a future on-chip sequencer to program TDR/TCR and poll TSR.
- Runs one transfer at a time: SETUP phase, then ACCESS phase with wait states, then a held response.
- An access-phase timeout guards against a responder that never asserts ready.

---
 rtl/apb_cmd_master.sv | 148 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//   APB initiator that turns a valid/ready command into one APB transfer
//   (SETUP, then ACCESS with wait states) and returns the result on a held
//   valid/ready response port. An ACCESS-phase timeout aborts transfers to a
//   responder that never asserts ready.
//
// Ports
//   apbm_clk, apbm_reset_n      clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_write/addr/wdata        command payload (sampled on accept)
//   rsp_valid/rsp_ready         response handshake (rsp_valid held)
//   rsp_rdata/slverr/timeout    response payload
//   apbm_sel/enable/write/address/wdata   APB request outputs
//   apbm_ready/slverr/rdata     APB completion inputs
// ---------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  apbm_clk,
  input  logic                  apbm_reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  apbm_sel,
  output logic                  apbm_enable,
  output logic                  apbm_write,
  output logic [ADDR_WIDTH-1:0] apbm_address,
  output logic [DATA_WIDTH-1:0] apbm_wdata,
  input  logic                  apbm_ready,
  input  logic                  apbm_slverr,
  input  logic [DATA_WIDTH-1:0] apbm_rdata
);

  // Counter is sized to hold TIMEOUT_CYCLES; keep at least one bit so the
  // disabled configuration still elaborates cleanly.
  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W:0]   TO_LIMIT = (TO_W + 1)'(TIMEOUT_CYCLES);
  localparam logic [TO_W:0]   TO_ONE   = (TO_W + 1)'(1);
  localparam logic [TO_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W:0]   to_cnt_inc;
  logic            to_expire;

  // One extra bit on the increment so the limit compare never aliases
  // through wrap-around.
  always_comb begin
    to_cnt_inc = {1'b0, to_cnt} + TO_ONE;
    to_expire  = (TIMEOUT_CYCLES != 0) && (to_cnt_inc == TO_LIMIT);
  end

  always_ff @(posedge apbm_clk) begin
    if (!apbm_reset_n) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_slverr   <= 1'b0;
      rsp_timeout  <= 1'b0;
      apbm_sel     <= 1'b0;
      apbm_enable  <= 1'b0;
      apbm_write   <= 1'b0;
      apbm_address <= '0;
      apbm_wdata   <= '0;
      to_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready is registered high throughout IDLE, so cmd_valid alone
          // marks the accepting edge.
          if (cmd_valid) begin
            cmd_ready    <= 1'b0;
            apbm_sel     <= 1'b1;
            apbm_write   <= cmd_write;
            apbm_address <= cmd_addr;
            apbm_wdata   <= cmd_wdata;
            to_cnt       <= '0;
            state        <= SETUP;
          end
        end

        SETUP: begin
          apbm_enable <= 1'b1;
          state       <= ACCESS;
        end

        ACCESS: begin
          // Ready takes priority over a timeout expiring in the same cycle.
          if (apbm_ready) begin
            apbm_sel    <= 1'b0;
            apbm_enable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_slverr  <= apbm_slverr;
            rsp_rdata   <= apbm_write ? '0 : apbm_rdata;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else begin
            if (to_cnt != CNT_MAX) begin
              to_cnt <= to_cnt_inc[TO_W-1:0];
            end
            if (to_expire) begin
              apbm_sel    <= 1'b0;
              apbm_enable <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_slverr  <= 1'b1;
              rsp_rdata   <= '0;
              rsp_timeout <= 1'b1;
              state       <= RESP;
            end
          end
        end

        RESP: begin
          // Response payload is left in place after the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            to_cnt    <= '0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr, rsp_timeout;
  logic          apbm_sel, apbm_enable, apbm_write;
  logic [AW-1:0] apbm_address;
  logic [DW-1:0] apbm_wdata;
  logic          apbm_ready  = 1'b0;
  logic          apbm_slverr = 1'b0;
  logic [DW-1:0] apbm_rdata  = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .apbm_clk(clk), .apbm_reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .apbm_sel(apbm_sel), .apbm_enable(apbm_enable), .apbm_write(apbm_write),
    .apbm_address(apbm_address), .apbm_wdata(apbm_wdata),
    .apbm_ready(apbm_ready), .apbm_slverr(apbm_slverr), .apbm_rdata(apbm_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: tracks whether a transfer is in flight, how
  // many edges since it was accepted, how many stalled ACCESS cycles, and
  // whether its response is pending.
  bit          m_on = 1'b0;
  bit          m_xfer, m_done;
  int          m_age, m_stalls;
  logic        m_write, m_slverr, m_timeout;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 1'b1; m_xfer = 1'b0; m_done = 1'b0; m_age = 0; m_stalls = 0;
      m_write = 1'b0; m_addr = '0; m_wdata = '0;
      m_rdata = '0; m_slverr = 1'b0; m_timeout = 1'b0;
    end else if (!m_xfer) begin
      if (cmd_valid) begin
        m_xfer = 1'b1; m_age = 1; m_stalls = 0;
        m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
      end
    end else if (m_done) begin
      if (rsp_ready) begin
        m_xfer = 1'b0; m_done = 1'b0;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (apbm_ready) begin
      m_done = 1'b1; m_slverr = apbm_slverr; m_timeout = 1'b0;
      m_rdata = m_write ? '0 : apbm_rdata;
    end else begin
      m_stalls++;
      if (TO != 0 && m_stalls >= TO) begin
        m_done = 1'b1; m_slverr = 1'b1; m_timeout = 1'b1; m_rdata = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("cmd_ready",    cmd_ready,    !m_xfer);
      chk("rsp_valid",    rsp_valid,    m_done);
      chk("apbm_sel",     apbm_sel,     m_xfer && !m_done);
      chk("apbm_enable",  apbm_enable,  m_xfer && !m_done && m_age >= 2);
      chk("apbm_write",   apbm_write,   m_write);
      chk("apbm_address", apbm_address, m_addr);
      chk("apbm_wdata",   apbm_wdata,   m_wdata);
      chk("rsp_rdata",    rsp_rdata,    m_rdata);
      chk("rsp_slverr",   rsp_slverr,   m_slverr);
      chk("rsp_timeout",  rsp_timeout,  m_timeout);
    end
  end

  // Responder: holds ready low for wait_n ACCESS cycles, then raises it.
  int wait_n  = 0;
  int acc_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (apbm_sel === 1'b1 && apbm_enable === 1'b1) begin
      acc_cnt++;
      apbm_ready = (acc_cnt > wait_n);
    end else begin
      acc_cnt    = 0;
      apbm_ready = 1'b0;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge (SETUP visible).
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) step;
    chk("issue_cmd_ready", cmd_ready, 1'b1);
    step;
    cmd_valid = 1'b0;
  endtask

  // Steps until rsp_valid, counting cycles with enable high on the way.
  task automatic wait_rsp(output int n_en);
    n_en = 0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid === 1'b1) break;
      if (apbm_enable === 1'b1) n_en++;
      step;
    end
    chk("rsp_valid_in_time", rsp_valid, 1'b1);
  endtask

  int n;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    repeat (2) step;
    rst_n = 1'b1;
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_sel", apbm_sel, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_address", apbm_address, 8'h00);
    step;

    // Write, zero wait states
    wait_n = 0;
    issue(1'b1, 8'h00, 8'h5A);
    chk("t1_setup_sel", apbm_sel, 1'b1);
    chk("t1_setup_en", apbm_enable, 1'b0);
    step;
    chk("t1_access_en", apbm_enable, 1'b1);
    chk("t1_access_addr", apbm_address, 8'h00);
    chk("t1_access_wdata", apbm_wdata, 8'h5A);
    chk("t1_access_write", apbm_write, 1'b1);
    step;
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_sel", apbm_sel, 1'b0);
    chk("t1_rsp_slverr", rsp_slverr, 1'b0);
    chk("t1_rsp_rdata", rsp_rdata, 8'h00);
    step;
    chk("t1_done_rsp_valid", rsp_valid, 1'b0);
    chk("t1_done_cmd_ready", cmd_ready, 1'b1);

    // Read with 3 wait states
    wait_n = 3; apbm_rdata = 8'h03; apbm_slverr = 1'b0;
    issue(1'b0, 8'h02, 8'hFF);
    wait_rsp(n);
    chk("t2_enable_cycles", n, 4);
    chk("t2_rdata", rsp_rdata, 8'h03);
    chk("t2_timeout", rsp_timeout, 1'b0);
    chk("t2_address", apbm_address, 8'h02);
    step;

    // Read with slave error
    wait_n = 0; apbm_rdata = 8'hA7; apbm_slverr = 1'b1;
    issue(1'b0, 8'h07, 8'h00);
    wait_rsp(n);
    chk("t3_slverr", rsp_slverr, 1'b1);
    chk("t3_timeout", rsp_timeout, 1'b0);
    chk("t3_rdata", rsp_rdata, 8'hA7);
    step;
    apbm_slverr = 1'b0;

    // Responder never ready: timeout
    wait_n = 1000; apbm_rdata = 8'hEE;
    issue(1'b0, 8'h10, 8'h00);
    wait_rsp(n);
    chk("t4_enable_cycles", n, 16);
    chk("t4_sel", apbm_sel, 1'b0);
    chk("t4_enable", apbm_enable, 1'b0);
    chk("t4_timeout", rsp_timeout, 1'b1);
    chk("t4_slverr", rsp_slverr, 1'b1);
    chk("t4_rdata", rsp_rdata, 8'h00);
    step;

    // Response back-pressure with a second command held on the port
    wait_n = 0; rsp_ready = 1'b0;
    issue(1'b1, 8'h03, 8'h11);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h04; cmd_wdata = 8'h22;
    wait_rsp(n);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_rsp_valid", rsp_valid, 1'b1);
      chk("t5_hold_cmd_ready", cmd_ready, 1'b0);
      chk("t5_hold_sel", apbm_sel, 1'b0);
      chk("t5_hold_rdata", rsp_rdata, 8'h00);
      chk("t5_hold_address", apbm_address, 8'h03);
      step;
    end
    rsp_ready = 1'b1;
    step;
    chk("t5_release_cmd_ready", cmd_ready, 1'b1);
    chk("t5_release_rsp_valid", rsp_valid, 1'b0);
    step;
    chk("t5_second_sel", apbm_sel, 1'b1);
    chk("t5_second_addr", apbm_address, 8'h04);
    chk("t5_second_wdata", apbm_wdata, 8'h22);
    cmd_valid = 1'b0;
    wait_rsp(n);
    step;

    // Reset during the second ACCESS cycle, then a normal write
    wait_n = 5;
    issue(1'b0, 8'h05, 8'h00);
    step;
    step;
    chk("t6_in_access", apbm_enable, 1'b1);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("t6_sel", apbm_sel, 1'b0);
    chk("t6_enable", apbm_enable, 1'b0);
    chk("t6_rsp_valid", rsp_valid, 1'b0);
    chk("t6_cmd_ready", cmd_ready, 1'b1);
    wait_n = 0;
    issue(1'b1, 8'h09, 8'h77);
    wait_rsp(n);
    chk("t6_enable_cycles", n, 1);
    chk("t6_slverr", rsp_slverr, 1'b0);
    chk("t6_rdata", rsp_rdata, 8'h00);
    chk("t6_timeout", rsp_timeout, 1'b0);
    step;
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
